// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt controller: issues vector jumps to the PC and
// keeps a return-address stack fed from / replayed onto the shared save/recovery bus.
module interrupt_controller #(
    parameter int NUM_IRQ     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [NUM_IRQ-1:0]               i_irq,
    input  logic [NUM_IRQ-1:0]               i_irq_mask,
    input  logic                             i_global_enable,
    input  logic [15:0]                      i_vector_base,
    input  logic                             i_reti,
    output logic                             o_interrupt_enable,
    output logic [15:0]                      o_interrupt_address,
    output logic                             o_recovery_enable,
    inout  wire  [15:0]                      io_interrupt_save_recovery,
    output logic [NUM_IRQ-1:0]               o_irq_ack,
    output logic                             o_in_service,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
    output logic                             o_underflow
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_SERVICE,
        ST_RETURN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [15:0]        stack_addr [STACK_DEPTH];
    logic [IDX_W-1:0]   stack_prio [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth;
    logic [IDX_W-1:0]   enter_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               cand_valid;
    logic               take;
    logic               underflow;
    logic [PTR_W-1:0]   top_ptr;
    logic [PTR_W-1:0]   push_ptr;

    assign top_ptr  = PTR_W'(depth - DEPTH_W'(1));
    assign push_ptr = PTR_W'(depth);
    assign eligible = pending & i_irq_mask;

    // Lowest-numbered enabled pending line wins
    always_comb begin
        cand_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_idx = IDX_W'(i);
            end
        end
        cand_valid = i_global_enable && (|eligible);
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cand_valid) begin
                    next_state = ST_ENTER;
                    take       = 1'b1;
                end
            end
            ST_ENTER: next_state = ST_SERVICE;
            ST_SERVICE: begin
                if (i_reti) begin
                    next_state = ST_RETURN;
                end else if (cand_valid && (cand_idx < stack_prio[top_ptr]) &&
                             (depth < DEPTH_W'(STACK_DEPTH))) begin
                    next_state = ST_ENTER;
                    take       = 1'b1;
                end
            end
            ST_RETURN: next_state = (depth > DEPTH_W'(1)) ? ST_SERVICE : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_irq_ack = '0;
        if (state == ST_ENTER) begin
            o_irq_ack[enter_idx] = 1'b1;
        end
    end

    // A new rising edge on the line being acked re-arms it (set wins over clear)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            irq_q     <= '0;
            pending   <= '0;
            depth     <= '0;
            enter_idx <= '0;
            underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_addr[i] <= '0;
                stack_prio[i] <= '0;
            end
        end else begin
            state   <= next_state;
            irq_q   <= i_irq;
            pending <= (pending & ~o_irq_ack) | (i_irq & ~irq_q);
            if (take) begin
                enter_idx <= cand_idx;
            end
            if ((state == ST_IDLE) && i_reti) begin
                underflow <= 1'b1;
            end
            if (state == ST_ENTER) begin
                stack_addr[push_ptr] <= io_interrupt_save_recovery;
                stack_prio[push_ptr] <= enter_idx;
                depth                <= depth + DEPTH_W'(1);
            end else if (state == ST_RETURN) begin
                depth <= depth - DEPTH_W'(1);
            end
        end
    end

    assign o_interrupt_enable  = (state == ST_ENTER);
    assign o_interrupt_address = o_interrupt_enable ? (i_vector_base + (16'(enter_idx) << 2)) : 16'h0000;
    assign o_recovery_enable   = (state == ST_RETURN);
    assign io_interrupt_save_recovery = o_recovery_enable ? stack_addr[top_ptr] : 16'hzzzz;
    assign o_in_service = (depth != '0);
    assign o_depth      = depth;
    assign o_underflow  = underflow;

endmodule
